// File: rtl/booth_pipe_ctrl.sv
// booth_pipe_ctrl: capture-enable sequencer for the 3-stage booth multiplier datapath.
// Each stage is tracked as EMPTY/SETTLE/FULL so no stage is overwritten before its downstream captures.
module booth_pipe_ctrl #(
    parameter int DLY1 = 0,
    parameter int DLY2 = 0,
    parameter int DLY3 = 0,
    parameter int CW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       lt1,
    output logic       lt2,
    output logic       lt3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] inflight
);
    typedef enum logic [1:0] {EMPTY, SETTLE, FULL} st_t;

    localparam logic [CW-1:0] DLY [3] = '{CW'(DLY1), CW'(DLY2), CW'(DLY3)};

    if (DLY1 > (1 << CW) - 1 || DLY2 > (1 << CW) - 1 || DLY3 > (1 << CW) - 1) begin : g_dly_chk
        $error("booth_pipe_ctrl: DLYn exceeds settle counter range 2^CW-1");
    end

    st_t           s     [3];
    st_t           s_n   [3];
    logic [CW-1:0] cnt   [3];
    logic [CW-1:0] cnt_n [3];
    logic [2:0]    lt;
    logic [2:0]    rel;
    logic          take3;
    logic [1:0]    inflight_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s        <= '{default: EMPTY};
            cnt      <= '{default: '0};
            inflight <= '0;
        end else begin
            s        <= s_n;
            cnt      <= cnt_n;
            inflight <= inflight_n;
        end
    end

    // Downstream-first chain lets a full pipeline advance in one cycle.
    always_comb begin
        out_valid = s[2] == FULL;
        take3     = out_valid & out_ready;
        lt3       = (s[1] == FULL) & (s[2] == EMPTY | take3) & ~flush;
        lt2       = (s[0] == FULL) & (s[1] == EMPTY | lt3) & ~flush;
        in_ready  = (s[0] == EMPTY | lt2) & ~flush;
        lt1       = in_valid & in_ready;
    end

    assign lt  = {lt3, lt2, lt1};
    assign rel = {take3, lt3, lt2};

    always_comb begin
        inflight_n = '0;
        for (int i = 0; i < 3; i++) begin
            s_n[i]   = s[i];
            cnt_n[i] = cnt[i];
            if (flush)
                s_n[i] = EMPTY;
            else if (lt[i]) begin
                s_n[i]   = DLY[i] == '0 ? FULL : SETTLE;
                cnt_n[i] = DLY[i];
            end else if (rel[i])
                s_n[i] = EMPTY;
            else if (s[i] == SETTLE) begin
                cnt_n[i] = cnt[i] - CW'(1);
                s_n[i]   = cnt[i] == CW'(1) ? FULL : SETTLE;
            end
            inflight_n = inflight_n + 2'(s_n[i] != EMPTY);
        end
    end
endmodule
